// File: rtl/traffic_phase_fsm_pkg.sv
// Shared types for the traffic phase controller: phase state encoding and lamp codes.
package traffic_phase_fsm_pkg;

  typedef enum logic [2:0] {
    NS_GRN   = 3'd0,
    NS_YEL   = 3'd1,
    ALLRED_A = 3'd2,
    EW_GRN   = 3'd3,
    EW_YEL   = 3'd4,
    ALLRED_B = 3'd5,
    FLASH    = 3'd6
  } phase_e;

  // Lamp codes are {red,yellow,green}
  localparam logic [2:0] LAMP_RED  = 3'b100;
  localparam logic [2:0] LAMP_YEL  = 3'b010;
  localparam logic [2:0] LAMP_GRN  = 3'b001;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  function automatic logic is_allred(input phase_e p);
    return (p == ALLRED_A) || (p == ALLRED_B);
  endfunction

endpackage

// File: rtl/traffic_phase_fsm_phase_timer.sv
// Per-phase tick counter: counts the selected prescaler tick and strobes done on the last one.
module traffic_phase_fsm_phase_timer
  import traffic_phase_fsm_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tc_2,
  input  logic             tc_10,
  input  logic             sel_10,
  input  logic             hold,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic             tick;
  logic [CNT_W-1:0] last;

  // Ticks landing in the prescaler-restart cycle are not counted
  assign tick = (sel_10 ? tc_10 : tc_2) & ~hold;
  assign last = limit - 1'b1;
  assign done = tick && (cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Traffic-light phase controller for two roads with pedestrian walk and night flashing.
module traffic_phase_fsm
  import traffic_phase_fsm_pkg::*;
#(
  parameter int unsigned GREEN_T   = 3,
  parameter int unsigned MIN_GREEN = 1,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tc_2,
  input  logic       tc_10,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       rst_q,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  phase_e           state, state_next;
  logic             ped_latch, latch_next;
  logic             walk, walk_next;
  logic             flash, flash_next;
  logic             state_change;
  logic             sel_10;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             t2_ok, t10_ok;
  logic             ped_cut;

  assign t2_ok   = tc_2 & ~rst_q;
  assign t10_ok  = tc_10 & ~rst_q;
  assign ped_cut = t10_ok && ped_latch && (cnt >= CNT_W'(MIN_GREEN));

  traffic_phase_fsm_phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .tc_2  (tc_2),
    .tc_10 (tc_10),
    .sel_10(sel_10),
    .hold  (rst_q),
    .clear (state_change || (state == FLASH)),
    .limit (limit),
    .cnt   (cnt),
    .done  (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ALLRED_A;
      ped_latch <= 1'b0;
      walk      <= 1'b0;
      flash     <= 1'b0;
      rst_q     <= 1'b1;
    end else begin
      state     <= state_next;
      ped_latch <= latch_next;
      walk      <= walk_next;
      flash     <= flash_next;
      rst_q     <= state_change;
    end
  end

  always_comb begin
    state_next = state;
    sel_10     = 1'b0;
    limit      = CNT_W'(ALLRED_T);
    case (state)
      NS_GRN, EW_GRN: begin
        sel_10 = 1'b1;
        limit  = CNT_W'(GREEN_T);
        if (done || ped_cut) state_next = (state == NS_GRN) ? NS_YEL : EW_YEL;
      end
      NS_YEL: begin
        limit = CNT_W'(YELLOW_T);
        if (done) state_next = ALLRED_A;
      end
      EW_YEL: begin
        limit = CNT_W'(YELLOW_T);
        if (done) state_next = ALLRED_B;
      end
      ALLRED_A, ALLRED_B: begin
        // A walk all-red is timed on the long tick instead of the short one
        sel_10 = walk;
        limit  = walk ? CNT_W'(WALK_T) : CNT_W'(ALLRED_T);
        if (done) begin
          if (night_mode)              state_next = FLASH;
          else if (state == ALLRED_A)  state_next = EW_GRN;
          else                         state_next = NS_GRN;
        end
      end
      FLASH: begin
        if (t2_ok && !night_mode) state_next = ALLRED_A;
      end
      default: state_next = ALLRED_A;
    endcase
  end

  assign state_change = (state_next != state);

  always_comb begin
    walk_next  = walk;
    flash_next = flash;
    latch_next = ped_latch;
    if (state_change) begin
      walk_next = is_allred(state_next) && ped_latch;
      if (is_allred(state_next)) latch_next = 1'b0;
    end
    if (state_change && (state_next == FLASH)) begin
      flash_next = 1'b1;
    end else if ((state == FLASH) && t2_ok && night_mode) begin
      flash_next = ~flash;
    end
    // Set wins over the clear so a press in the entry cycle is kept for the next all-red
    if (ped_req && (state != FLASH)) latch_next = 1'b1;
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (state)
      NS_GRN: ns_light = LAMP_GRN;
      NS_YEL: ns_light = LAMP_YEL;
      EW_GRN: ew_light = LAMP_GRN;
      EW_YEL: ew_light = LAMP_YEL;
      FLASH: begin
        ns_light = flash ? LAMP_YEL : LAMP_DARK;
        ew_light = flash ? LAMP_YEL : LAMP_DARK;
      end
      default: ;
    endcase
  end

  assign ped_walk = walk && is_allred(state);
  assign phase    = state;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed self-checking bench for traffic_phase_fsm with hand-derived expectations.
module tb_traffic_phase_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tc_2 = 1'b0, tc_10 = 1'b0, ped_req = 1'b0, night_mode = 1'b0;
  logic       rst_q, ped_walk;
  logic [2:0] ns_light, ew_light, phase;
  int         compared = 0;
  int         mismatched = 0;

  traffic_phase_fsm #(
    .GREEN_T(3), .MIN_GREEN(1), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .tc_2(tc_2), .tc_10(tc_10), .ped_req(ped_req),
    .night_mode(night_mode), .rst_q(rst_q), .ns_light(ns_light), .ew_light(ew_light),
    .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // Continuous properties: never two greens, rst_q never wider than one cycle
  logic rst_q_d = 1'b0;
  logic rst_d = 1'b1;
  always @(negedge clk) begin
    compared++;
    if (ns_light == 3'b001 && ew_light == 3'b001) begin
      mismatched++;
      $display("FAIL both_green ns=%b ew=%b required not both 001", ns_light, ew_light);
    end
    if (!rst && !rst_d) begin
      compared++;
      if (rst_q && rst_q_d) begin
        mismatched++;
        $display("FAIL rst_q_width got two consecutive high cycles, required 1");
      end
    end
    rst_q_d <= rst_q;
    rst_d   <= rst;
  end

  task automatic cyc(input logic t2, input logic t10);
    tc_2 = t2; tc_10 = t10;
    @(posedge clk); #1;
    tc_2 = 1'b0; tc_10 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tc_2 = 1'b0; tc_10 = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // From reset, walk to the first cycle of NS_GRN after its rst_q cycle (cnt=0)
  task automatic go_ns_grn();
    do_reset();
    cyc(0, 0); cyc(1, 0);
    cyc(0, 0); cyc(0, 1); cyc(0, 1); cyc(0, 1);
    cyc(0, 0); cyc(1, 0); cyc(1, 0);
    cyc(0, 0); cyc(1, 0);
    cyc(0, 0);
  endtask

  function automatic logic [2:0] exp_phase(input int k);
    if (k < 2)       return 3'd2;
    else if (k < 30) return 3'd3;
    else if (k < 34) return 3'd4;
    else if (k < 36) return 3'd5;
    else if (k < 60) return 3'd0;
    else if (k < 64) return 3'd1;
    else if (k < 66) return 3'd2;
    else             return 3'd3;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    compared++; if (phase !== 3'd2) begin mismatched++; $display("FAIL reset_phase got=%0d exp=2", phase); end
    compared++; if (rst_q !== 1'b1) begin mismatched++; $display("FAIL reset_rst_q got=%b exp=1", rst_q); end
    compared++; if (ns_light !== 3'b100 || ew_light !== 3'b100) begin mismatched++; $display("FAIL reset_lamps got=%b/%b exp=100/100", ns_light, ew_light); end
    compared++; if (ped_walk !== 1'b0) begin mismatched++; $display("FAIL reset_walk got=%b exp=0", ped_walk); end
  endtask

  task automatic test_default_cycle();
    logic [2:0] ep, ens, eew;
    logic       erq;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      ep  = exp_phase(k);
      erq = (k == 0 || k == 2 || k == 30 || k == 34 || k == 36 || k == 60 || k == 64 || k == 66);
      ens = (ep == 3'd0) ? 3'b001 : (ep == 3'd1) ? 3'b010 : 3'b100;
      eew = (ep == 3'd3) ? 3'b001 : (ep == 3'd4) ? 3'b010 : 3'b100;
      compared++; if (phase !== ep) begin mismatched++; $display("FAIL cycle_phase k=%0d got=%0d exp=%0d", k, phase, ep); end
      compared++; if (rst_q !== erq) begin mismatched++; $display("FAIL cycle_rst_q k=%0d got=%b exp=%b", k, rst_q, erq); end
      compared++; if (ns_light !== ens || ew_light !== eew) begin mismatched++; $display("FAIL cycle_lamps k=%0d got=%b/%b exp=%b/%b", k, ns_light, ew_light, ens, eew); end
      cyc((k % 2) == 1, (k % 10) == 9);
    end
  endtask

  task automatic test_tick_during_rst_q();
    do_reset();
    cyc(0, 0); cyc(1, 0);
    compared++; if (rst_q !== 1'b1 || phase !== 3'd3) begin mismatched++; $display("FAIL rq_entry got rst_q=%b phase=%0d exp 1/3", rst_q, phase); end
    cyc(0, 1); cyc(0, 1); cyc(0, 1);
    compared++; if (phase !== 3'd3) begin mismatched++; $display("FAIL rq_green_len phase got=%0d exp=3", phase); end
    cyc(0, 1);
    compared++; if (phase !== 3'd4) begin mismatched++; $display("FAIL rq_green_exit phase got=%0d exp=4", phase); end
    cyc(0, 0); cyc(1, 1);
    compared++; if (phase !== 3'd4) begin mismatched++; $display("FAIL both_ticks_yel phase got=%0d exp=4", phase); end
    cyc(1, 1);
    compared++; if (phase !== 3'd5) begin mismatched++; $display("FAIL both_ticks_exit phase got=%0d exp=5", phase); end
  endtask

  task automatic test_ped_served();
    go_ns_grn();
    cyc(0, 1);
    ped_req = 1'b1; cyc(0, 0); ped_req = 1'b0;
    compared++; if (phase !== 3'd0 || ped_walk !== 1'b0) begin mismatched++; $display("FAIL ped_latched got phase=%0d walk=%b exp 0/0", phase, ped_walk); end
    cyc(0, 1);
    compared++; if (phase !== 3'd1) begin mismatched++; $display("FAIL ped_cut phase got=%0d exp=1", phase); end
    cyc(0, 0); cyc(1, 0); cyc(1, 0);
    compared++; if (phase !== 3'd2 || ped_walk !== 1'b1) begin mismatched++; $display("FAIL walk_entry got phase=%0d walk=%b exp 2/1", phase, ped_walk); end
    cyc(1, 0); cyc(1, 0);
    compared++; if (phase !== 3'd2 || ped_walk !== 1'b1) begin mismatched++; $display("FAIL walk_ignores_tc2 got phase=%0d walk=%b exp 2/1", phase, ped_walk); end
    ped_req = 1'b1; cyc(0, 1); ped_req = 1'b0;
    compared++; if (phase !== 3'd2 || ped_walk !== 1'b1) begin mismatched++; $display("FAIL walk_len got phase=%0d walk=%b exp 2/1", phase, ped_walk); end
    cyc(0, 1);
    compared++; if (phase !== 3'd3 || ped_walk !== 1'b0) begin mismatched++; $display("FAIL walk_exit got phase=%0d walk=%b exp 3/0", phase, ped_walk); end
    cyc(0, 0); cyc(0, 1); cyc(0, 1);
    compared++; if (phase !== 3'd4) begin mismatched++; $display("FAIL relatch_cut phase got=%0d exp=4", phase); end
    cyc(0, 0); cyc(1, 0); cyc(1, 0);
    compared++; if (phase !== 3'd5 || ped_walk !== 1'b1) begin mismatched++; $display("FAIL relatch_walk got phase=%0d walk=%b exp 5/1", phase, ped_walk); end
  endtask

  task automatic test_ped_min_green();
    go_ns_grn();
    ped_req = 1'b1; cyc(0, 0); ped_req = 1'b0;
    cyc(0, 1);
    compared++; if (phase !== 3'd0) begin mismatched++; $display("FAIL min_green_hold phase got=%0d exp=0", phase); end
    cyc(0, 1);
    compared++; if (phase !== 3'd1) begin mismatched++; $display("FAIL min_green_cut phase got=%0d exp=1", phase); end
    cyc(0, 0); cyc(1, 0); cyc(1, 0);
    compared++; if (phase !== 3'd2 || ped_walk !== 1'b1) begin mismatched++; $display("FAIL min_green_walk got phase=%0d walk=%b exp 2/1", phase, ped_walk); end
    cyc(0, 0); cyc(0, 1); cyc(0, 1);
    cyc(0, 0); cyc(0, 1); cyc(0, 1);
    compared++; if (phase !== 3'd3) begin mismatched++; $display("FAIL latch_cleared phase got=%0d exp=3", phase); end
    cyc(0, 1);
    compared++; if (phase !== 3'd4) begin mismatched++; $display("FAIL full_green_exit phase got=%0d exp=4", phase); end
  endtask

  task automatic test_night_flash();
    do_reset();
    cyc(0, 0); cyc(1, 0);
    cyc(0, 0); cyc(0, 1); cyc(0, 1); cyc(0, 1);
    night_mode = 1'b1;
    cyc(0, 0); cyc(1, 0); cyc(1, 0);
    compared++; if (phase !== 3'd5) begin mismatched++; $display("FAIL night_allred phase got=%0d exp=5", phase); end
    cyc(0, 0); cyc(1, 0);
    compared++; if (phase !== 3'd6 || rst_q !== 1'b1) begin mismatched++; $display("FAIL flash_entry got phase=%0d rst_q=%b exp 6/1", phase, rst_q); end
    compared++; if (ns_light !== 3'b010 || ew_light !== 3'b010 || ped_walk !== 1'b0) begin mismatched++; $display("FAIL flash_lit0 got %b/%b walk=%b exp 010/010/0", ns_light, ew_light, ped_walk); end
    ped_req = 1'b1; cyc(1, 0); ped_req = 1'b0;
    compared++; if (ns_light !== 3'b010 || ew_light !== 3'b010) begin mismatched++; $display("FAIL flash_rq_ignored got %b/%b exp 010/010", ns_light, ew_light); end
    cyc(1, 0);
    compared++; if (ns_light !== 3'b000 || ew_light !== 3'b000) begin mismatched++; $display("FAIL flash_dark got %b/%b exp 000/000", ns_light, ew_light); end
    cyc(1, 0);
    compared++; if (ns_light !== 3'b010 || ew_light !== 3'b010) begin mismatched++; $display("FAIL flash_lit1 got %b/%b exp 010/010", ns_light, ew_light); end
    cyc(0, 1);
    compared++; if (ns_light !== 3'b010) begin mismatched++; $display("FAIL flash_tc10 got %b exp 010", ns_light); end
    night_mode = 1'b0;
    cyc(0, 0);
    compared++; if (phase !== 3'd6) begin mismatched++; $display("FAIL flash_wait phase got=%0d exp=6", phase); end
    cyc(1, 0);
    compared++; if (phase !== 3'd2 || rst_q !== 1'b1 || ns_light !== 3'b100) begin mismatched++; $display("FAIL flash_exit got phase=%0d rst_q=%b ns=%b exp 2/1/100", phase, rst_q, ns_light); end
    compared++; if (ped_walk !== 1'b0) begin mismatched++; $display("FAIL flash_ped_ignored walk got=%b exp=0", ped_walk); end
    cyc(0, 0); cyc(1, 0);
    cyc(0, 0); cyc(0, 1); cyc(0, 1);
    compared++; if (phase !== 3'd3) begin mismatched++; $display("FAIL flash_no_latch phase got=%0d exp=3", phase); end
  endtask

  task automatic test_reset_mid_phase();
    do_reset();
    cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(0, 1);
    compared++; if (phase !== 3'd3 || ew_light !== 3'b001) begin mismatched++; $display("FAIL pre_reset got phase=%0d ew=%b exp 3/001", phase, ew_light); end
    #2 rst = 1'b1;
    #1;
    compared++; if (phase !== 3'd2 || rst_q !== 1'b1) begin mismatched++; $display("FAIL async_reset got phase=%0d rst_q=%b exp 2/1", phase, rst_q); end
    compared++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || ped_walk !== 1'b0) begin mismatched++; $display("FAIL async_reset_lamps got %b/%b walk=%b exp 100/100/0", ns_light, ew_light, ped_walk); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_tick_during_rst_q();
    test_ped_served();
    test_ped_min_green();
    test_night_flash();
    test_reset_mid_phase();
    cyc(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
